// File: rtl/fifo_rd_stream_pkg.sv
// Shared widths and occupancy type for the read-side stream stage of the async FIFO.
package fifo_rd_stream_pkg;
   localparam int DATAWIDTH  = 8;
   localparam int ADDR_WIDTH = 4;
   localparam int CNTWIDTH   = 16;

   typedef logic [1:0] occ_t;

   localparam occ_t OCC_EMPTY = 2'd0;
   localparam occ_t OCC_FULL  = 2'd2;
endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream; master is the stream stage, slave its surroundings.
interface fifo_rd_stream_if
   import fifo_rd_stream_pkg::*;
#(
   parameter int datawidth = DATAWIDTH,
   parameter int cntwidth  = CNTWIDTH
);
   logic                 rempty;
   logic [datawidth-1:0] rdata;
   logic                 rinc;
   logic                 flush;
   logic                 m_valid;
   logic [datawidth-1:0] m_data;
   logic                 m_ready;
   logic [cntwidth-1:0]  m_count;

   modport master (
      input  rempty, rdata, flush, m_ready,
      output rinc, m_valid, m_data, m_count
   );

   modport slave (
      output rempty, rdata, flush, m_ready,
      input  rinc, m_valid, m_data, m_count
   );
endinterface

// File: rtl/fifo_rd_stream_skid2.sv
// Two-entry registered circular queue; the head word is always presented straight from a flop.
module fifo_rd_stream_skid2
   import fifo_rd_stream_pkg::*;
#(
   parameter int width = DATAWIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [width-1:0] pushData_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output occ_t             occ_o,
   output logic [width-1:0] headData_o
);
   logic [width-1:0] mem_q [2];
   logic [width-1:0] mem_d [2];
   logic             head_q, head_d;
   logic             tail_q, tail_d;
   occ_t             occ_q, occ_d;

   // Flush wins over push and pop so no word can slip in on the clearing edge.
   always_comb begin
      mem_d  = mem_q;
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (flush_i) begin
         head_d = 1'b0;
         tail_d = 1'b0;
         occ_d  = OCC_EMPTY;
      end else begin
         if (push_i) begin
            mem_d[tail_q] = pushData_i;
            tail_d        = ~tail_q;
         end
         if (pop_i) begin
            head_d = ~head_q;
         end
         occ_d = occ_q + occ_t'(push_i) - occ_t'(pop_i);
      end
   end

   // Storage is cleared on reset so the output word reads zero before anything arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         head_q   <= 1'b0;
         tail_q   <= 1'b0;
         occ_q    <= OCC_EMPTY;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         head_q   <= head_d;
         tail_q   <= tail_d;
         occ_q    <= occ_d;
      end
   end

   assign occ_o      = occ_q;
   assign headData_o = mem_q[head_q];
endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a 2-deep buffer and presents it as a valid/ready stream.
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int datawidth = DATAWIDTH,
   parameter int cntwidth  = CNTWIDTH
) (
   input  logic               rclk,
   input  logic               rrst_n,
   fifo_rd_stream_if.master   bus
);
   occ_t                occ;
   logic                handshake;
   logic [cntwidth-1:0] count_q, count_d;

   // Pop only depends on local occupancy, never on m_ready, keeping the FIFO path short.
   assign bus.rinc    = rrst_n & ~bus.rempty & ~bus.flush & (occ != OCC_FULL);
   assign bus.m_valid = (occ != OCC_EMPTY);
   assign handshake   = bus.m_valid & bus.m_ready & ~bus.flush;

   fifo_rd_stream_skid2 #(
      .width (datawidth)
   ) u_skid2 (
      .clk        (rclk),
      .rst_n      (rrst_n),
      .push_i     (bus.rinc),
      .pushData_i (bus.rdata),
      .pop_i      (handshake),
      .flush_i    (bus.flush),
      .occ_o      (occ),
      .headData_o (bus.m_data)
   );

   // Delivered-word counter survives flush and wraps naturally.
   always_comb begin
      count_d = count_q;
      if (handshake) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign bus.m_count = count_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: a behavioural FIFO read port feeds two stream stages (16-bit and 4-bit counters).
module tb_fifo_rd_stream;
   logic       rclk;
   logic       rrst_n = 1'b1;
   logic [7:0] fifoMem [256];
   logic [7:0] wrPtr;
   logic [7:0] rdPtr;
   int         compared;
   int         mismatched;

   fifo_rd_stream_if #(.datawidth(8), .cntwidth(16)) bus  ();
   fifo_rd_stream_if #(.datawidth(8), .cntwidth(4))  busN ();

   fifo_rd_stream #(.datawidth(8), .cntwidth(16)) dut (
      .rclk   (rclk),
      .rrst_n (rrst_n),
      .bus    (bus)
   );

   fifo_rd_stream #(.datawidth(8), .cntwidth(4)) dutN (
      .rclk   (rclk),
      .rrst_n (rrst_n),
      .bus    (busN)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   assign bus.rempty  = (wrPtr == rdPtr);
   assign bus.rdata   = fifoMem[rdPtr];
   assign busN.rempty = bus.rempty;
   assign busN.rdata  = bus.rdata;
   assign busN.flush  = bus.flush;
   assign busN.m_ready = bus.m_ready;

   // The FIFO read pointer advances on the pop edge and shares the read-domain reset.
   always @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rdPtr <= 8'd0;
      end else if (bus.rinc) begin
         rdPtr <= rdPtr + 8'd1;
      end
   end

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic pushWord(input logic [7:0] d);
      fifoMem[wrPtr] = d;
      wrPtr = wrPtr + 8'd1;
   endtask

   task automatic applyStimulus(input logic ready, input logic fl);
      bus.m_ready = ready;
      bus.flush   = fl;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkStream(input string tag, input logic v, input logic [7:0] d,
                              input logic [15:0] cnt, input logic ri);
      checkOutput({tag, ".m_valid"}, 32'(bus.m_valid), 32'(v));
      if (v) checkOutput({tag, ".m_data"}, 32'(bus.m_data), 32'(d));
      checkOutput({tag, ".m_count"}, 32'(bus.m_count), 32'(cnt));
      checkOutput({tag, ".rinc"}, 32'(bus.rinc), 32'(ri));
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      wrPtr      = 8'd0;
      applyStimulus(1'b0, 1'b0);
      rrst_n = 1'b0;
      tick();
      tick();
      checkStream("reset", 1'b0, 8'h00, 16'd0, 1'b0);
      checkOutput("reset.m_data", 32'(bus.m_data), 32'h0);
      rrst_n = 1'b1;
      tick();
      tick();
      checkStream("idle", 1'b0, 8'h00, 16'd0, 1'b0);

      // Streaming: one delivery per edge, occupancy stays at one.
      applyStimulus(1'b1, 1'b0);
      for (int i = 1; i <= 8; i++) pushWord(8'(i));
      #1;
      checkStream("stream.first", 1'b0, 8'h00, 16'd0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         tick();
         checkStream("stream", 1'b1, 8'(i + 1), 16'(i), (i < 7));
      end
      tick();
      checkStream("stream.end", 1'b0, 8'h00, 16'd8, 1'b0);

      // Empty boundary: idle for ten cycles, then a single late word.
      for (int i = 0; i < 10; i++) begin
         tick();
         checkStream("gap", 1'b0, 8'h00, 16'd8, 1'b0);
      end
      pushWord(8'h55);
      #1;
      checkStream("late.pop", 1'b0, 8'h00, 16'd8, 1'b1);
      tick();
      checkStream("late.out", 1'b1, 8'h55, 16'd8, 1'b0);
      tick();
      checkStream("late.done", 1'b0, 8'h00, 16'd9, 1'b0);

      // Backpressure: two pops fill the buffer, head word held stable.
      applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) pushWord(8'hA0 + 8'(i));
      #1;
      tick();
      checkStream("bp.one", 1'b1, 8'hA0, 16'd9, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkStream("bp.full", 1'b1, 8'hA0, 16'd9, 1'b0);
      end
      applyStimulus(1'b1, 1'b0);
      #1;
      checkOutput("bp.readyNoComb", 32'(bus.rinc), 32'h0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         checkStream("bp.drain", 1'b1, 8'hA0 + 8'(i), 16'(9 + i), (i < 4));
      end
      tick();
      checkStream("bp.done", 1'b0, 8'h00, 16'd14, 1'b0);

      // Flush at full occupancy with a concurrent handshake.
      applyStimulus(1'b0, 1'b0);
      pushWord(8'h11);
      pushWord(8'h22);
      pushWord(8'h33);
      tick();
      tick();
      checkStream("fl.full", 1'b1, 8'h11, 16'd14, 1'b0);
      applyStimulus(1'b1, 1'b1);
      #1;
      checkOutput("fl.noPop", 32'(bus.rinc), 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0);
      #1;
      checkStream("fl.after", 1'b0, 8'h00, 16'd14, 1'b1);
      tick();
      checkStream("fl.next", 1'b1, 8'h33, 16'd14, 1'b0);
      tick();
      checkStream("fl.nextDone", 1'b0, 8'h00, 16'd15, 1'b0);

      // Flush with an empty buffer and a waiting FIFO word must not pop it.
      applyStimulus(1'b0, 1'b1);
      pushWord(8'h66);
      #1;
      checkOutput("fl2.noPop", 32'(bus.rinc), 32'h0);
      tick();
      checkOutput("fl2.kept", 32'(bus.rempty), 32'h0);
      applyStimulus(1'b0, 1'b0);
      #1;
      checkOutput("fl2.pop", 32'(bus.rinc), 32'h1);
      tick();
      checkStream("fl2.out", 1'b1, 8'h66, 16'd15, 1'b0);
      applyStimulus(1'b1, 1'b0);
      tick();
      checkStream("fl2.done", 1'b0, 8'h00, 16'd16, 1'b0);
      checkOutput("wrap.zero", 32'(busN.m_count), 32'h0);

      // Two more words bring the total to 18; the 4-bit counter wraps to 2.
      pushWord(8'h77);
      pushWord(8'h78);
      tick();
      tick();
      tick();
      checkStream("wrap.done", 1'b0, 8'h00, 16'd18, 1'b0);
      checkOutput("wrap.narrow", 32'(busN.m_count), 32'h2);

      // Reset mid-traffic clears outputs immediately.
      for (int i = 0; i < 4; i++) pushWord(8'h90 + 8'(i));
      tick();
      tick();
      checkStream("mid.run", 1'b1, 8'h91, 16'd19, 1'b1);
      rrst_n = 1'b0;
      wrPtr  = 8'd0;
      #1;
      checkStream("mid.reset", 1'b0, 8'h00, 16'd0, 1'b0);
      checkOutput("mid.narrow", 32'(busN.m_count), 32'h0);
      tick();
      rrst_n = 1'b1;
      tick();
      tick();
      checkStream("mid.idle", 1'b0, 8'h00, 16'd0, 1'b0);
      checkOutput("mid.m_data", 32'(bus.m_data), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side output stage of the async FIFO, running entirely in the read clock domain. Drains the FIFO through its `rinc`/`rempty`/`rdata` read port and re-presents the data as a valid/ready stream, backed by a 2-entry output buffer. The consumer can stall freely without losing words, and throughput is one word per `rclk` while the consumer is ready. Also provides a synchronous flush and a delivered-word counter for debug.

## Interface
- `datawidth`, 8: word width; must equal the FIFO `datawidth`.
- `cntwidth`, 16: width of the delivered-word counter.

- `rclk` in 1: read-domain clock; all logic is clocked on its rising edge.
- `rrst_n` in 1: reset, asynchronous and active-low.
- `rempty` in 1: FIFO empty flag.
- `rdata` in `datawidth`: FIFO read data. It is combinational from the FIFO read address and is valid whenever `rempty`=0.
- `rinc` out 1: FIFO pop request. The word on `rdata` is consumed at the same edge.
- `flush` in 1: synchronous clear of the output buffer.
- `m_valid` out 1: output word valid.
- `m_data` out `datawidth`: output word.
- `m_ready` in 1: consumer ready.
- `m_count` out `cntwidth`: number of words delivered, i.e. output handshakes.

## Operation
- Buffer: 2-entry circular queue. State consists of `head` (1 bit), `tail` (1 bit) and `occ` (0..2).
- Pop rule: `rinc = ~rempty & ~flush & (occ != 2)`. This is combinational.
- On an edge where `rinc`=1:
  - the current `rdata` is written to `buf[tail]`;
  - `tail` toggles.
- Output side:
  - `m_valid = (occ != 0)`.
  - `m_data = buf[head]`. This is a registered value with no combinational path from `rdata`.
- Handshake: a word is delivered on an edge where `m_valid & m_ready`. On that edge `head` toggles and `m_count` increments.
- `occ` update on each edge: `occ_next = occ + rinc - (m_valid & m_ready)`.
  - A simultaneous pop and delivery leaves `occ` unchanged.
  - Pop and delivery may occur together at `occ`=1. At `occ`=2, `rinc` is 0. At `occ`=0, `m_valid` is 0.
- Valid stability: once `m_valid`=1, `m_valid` and `m_data` hold until a handshake occurs or `flush` is asserted.
- Ordering: words are delivered in exact FIFO order; none are dropped or duplicated unless `flush` is used.
- `m_count`:
  - wraps modulo 2^`cntwidth`;
  - is not cleared by `flush`, only by reset.
- `flush`=1 at an edge:
  - `occ`, `head` and `tail` are cleared to 0; buffered words are discarded;
  - no pop occurs that cycle;
  - a handshake in the same cycle is ignored: no `m_count` increment and no consumer-visible completion.

  The FIFO contents themselves are not touched by `flush`.

## Timing
- Reset (`rrst_n`=0, asynchronous): `occ`=0, `head`=0, `tail`=0, `m_valid`=0, `m_count`=0, `m_data`=0, `rinc`=0. Buffer storage contents are don't-care, but `m_data` reads 0 while `occ`=0 after reset.
- Latency, from `rempty` falling with an empty buffer and `m_ready`=1:
  - `rinc`=1 in the same cycle;
  - `m_valid`=1 after 1 `rclk` edge;
  - first handshake in the following cycle.
- Throughput: with `m_ready` held at 1 and the FIFO never empty, there is one pop and one delivery every cycle, and `occ` stays at 1.
- Stall: with `m_ready`=0, at most 2 further pops occur, then `rinc` stays at 0 until a handshake.
- Resume from `occ`=2 with `m_ready`=1: the handshake occurs that cycle, and `rinc` reasserts in the next cycle (`occ`=1).
- Reset asserted mid-operation: the buffer is emptied immediately and `m_valid` drops asynchronously. The FIFO read pointer shares `rrst_n`, so both sides restart consistently.
- The sole combinational path through the block is `rempty`/`flush`/`occ` → `rinc`. There is no combinational path from `m_ready` to `rinc`.

## Structure
- Shared package: `datawidth` and `addr_width` defaults, and `cntwidth`.
- Sub-module `skid2` (2-entry registered queue with push/pop/flush and an `occ` output). The top level holds the pop rule and `m_count`.
- Instantiated in the read domain next to the FIFO:
  - `rinc` drives the FIFO `rinc`;
  - FIFO `rdata`/`rempty` feed this block.

## Test plan
- Reset: assert `rrst_n`=0 mid-traffic → `m_valid`=0, `m_count`=0, `rinc`=0 immediately; after release with FIFO empty, outputs stay idle.
- Streaming: write 0x01..0x08 into the FIFO, `m_ready`=1 → `m_data` delivers 0x01..0x08 on consecutive cycles with no gaps; `m_count`=8; `occ` never exceeds 1.
- Backpressure: FIFO holds 0xA0..0xA4, `m_ready`=0 → exactly 2 pops (`occ`=2); `m_data`=0xA0 is held stable. Release `m_ready` → 0xA0..0xA4 in order, nothing lost.
- Empty boundary: FIFO becomes empty during streaming → `rinc`=0 while `rempty`=1; `m_valid` drops after the last word; a write 10 cycles later resumes delivery correctly.
- Flush: `occ`=2 holding 0x11,0x22, with `flush`=1 and `m_ready`=1 in the same cycle → next cycle `m_valid`=0, `m_count` unchanged, no `rinc` that cycle; the next FIFO word 0x33 is delivered afterwards.
- Counter wrap: `cntwidth`=4, deliver 18 words → `m_count`=2.
